// File: rtl/program_loader_pkg.sv
// ----------------------------------------------------------------------------
// program_loader_pkg
// Purpose : Shared types, defaults and helpers for the program loader.
//           Holds the loader FSM state encoding, the default buffer depth and
//           core reset hold time, and small helper functions used by the
//           loader datapath.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package program_loader_pkg;

    // Default depth of the core's init instruction buffer (words)
    localparam int DEF_MAX_INSTS  = 16;

    // Default number of cycles the core stays in reset after the last word
    localparam int DEF_RESET_HOLD = 4;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_PC  = 3'd1,
        ST_HDR_CNT = 3'd2,
        ST_LOAD    = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RUN     = 3'd5,
        ST_DONE    = 3'd6
    } loader_state_e;

    // A frame word count is unusable when it is zero or larger than the buffer
    function automatic logic count_is_bad(input logic [31:0] n,
                                          input logic [31:0] max_insts);
        return (n == 32'd0) || (n > max_insts);
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
// Purpose : Bundles the loader's host stream, core control and status
//           signals into one interface.
// Signals : _start          host -> loader  begin a load (IDLE/DONE only)
//           _in_valid       host -> loader  stream word valid
//           _in_data[31:0]  host -> loader  stream word
//           in_ready_       loader -> host  word accepted when valid & ready
//           _core_finished  core -> loader  core ebreak / finished
//           core_reset_     loader -> core  core reset
//           init_pc_        loader -> core  start PC
//           init_inst_buf_  loader -> core  MAX_INSTS x 32 instruction buffer
//           busy_           loader -> host  high from HDR_PC through RUN
//           done_           loader -> host  high in DONE
//           error_          loader -> host  bad word count, sticky
//           run_cycles_     loader -> host  cycles spent in RUN, saturating
// Modports: master = loader side, slave = host/core side
// ----------------------------------------------------------------------------
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int MAX_INSTS = DEF_MAX_INSTS
);

    logic                          _start;
    logic                          _in_valid;
    logic [31:0]                   _in_data;
    logic                          in_ready_;
    logic                          _core_finished;
    logic                          core_reset_;
    logic [31:0]                   init_pc_;
    logic [MAX_INSTS-1:0][31:0]    init_inst_buf_;
    logic                          busy_;
    logic                          done_;
    logic                          error_;
    logic [31:0]                   run_cycles_;

    modport master (
        input  _start, _in_valid, _in_data, _core_finished,
        output in_ready_, core_reset_, init_pc_, init_inst_buf_,
               busy_, done_, error_, run_cycles_
    );

    modport slave (
        output _start, _in_valid, _in_data, _core_finished,
        input  in_ready_, core_reset_, init_pc_, init_inst_buf_,
               busy_, done_, error_, run_cycles_
    );

endinterface

// File: rtl/loader_hold_counter.sv
// ----------------------------------------------------------------------------
// loader_hold_counter
// Purpose : Loadable down-counter with a zero flag. The loader uses it to
//           time how long the core is kept in reset after the last word.
// Ports   : clk       in   clock
//           rst       in   synchronous active-high reset (count -> 0)
//           load      in   load load_val this cycle (wins over dec)
//           load_val  in   W  value to load
//           dec       in   decrement by one; never goes below zero
//           zero      out  count is zero
// ----------------------------------------------------------------------------
module loader_hold_counter
    import program_loader_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; a decrement at zero is ignored so the count cannot wrap
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Purpose : Receives a program frame {start PC, count N, N instructions} as a
//           valid/ready word stream, fills the core's init instruction buffer
//           and start PC while holding the core in reset, releases the core
//           RESET_HOLD+1 cycles after the last word, then counts run cycles
//           until the core signals finished.
// Params  : MAX_INSTS   depth of the instruction buffer (words)
//           RESET_HOLD  cycles core reset stays high after the last word
// Ports   : _clk    in  clock
//           _reset  in  synchronous active-high reset
//           bus     program_loader_if.master (stream, core control, status)
// ----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MAX_INSTS  = DEF_MAX_INSTS,
    parameter int RESET_HOLD = DEF_RESET_HOLD
) (
    input  logic               _clk,
    input  logic               _reset,
    program_loader_if.master   bus
);

    localparam int IDX_W  = $clog2(MAX_INSTS) + 1;
    localparam int HOLD_W = $clog2(RESET_HOLD) + 1;

    loader_state_e              state_q, state_d;
    logic [31:0]                pc_q, pc_d;
    logic [MAX_INSTS-1:0][31:0] buf_q, buf_d;
    logic [IDX_W-1:0]           n_q, n_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       error_q, error_d;
    logic [31:0]                run_cycles_q, run_cycles_d;

    logic                       in_ready;
    logic                       accept;
    logic                       hold_load;
    logic                       hold_dec;
    logic                       hold_zero;

    // Ready depends only on state so that accept never loops back through
    // the next-state logic.
    assign in_ready = (state_q == ST_HDR_PC) || (state_q == ST_HDR_CNT) ||
                      (state_q == ST_LOAD);
    assign accept   = bus._in_valid && in_ready;

    // Times the reset hold after the last instruction word. It is loaded
    // with RESET_HOLD-1 so that zero is reached on the last HOLD cycle.
    loader_hold_counter #(
        .W (HOLD_W)
    ) u_hold_counter (
        .clk      (_clk),
        .rst      (_reset),
        .load     (hold_load),
        .load_val (HOLD_W'(RESET_HOLD - 1)),
        .dec      (hold_dec),
        .zero     (hold_zero)
    );

    // Next-state and datapath updates. Everything holds by default; each
    // state only overrides what it changes.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        n_d          = n_q;
        idx_d        = idx_q;
        error_d      = error_q;
        run_cycles_d = run_cycles_q;
        hold_load    = 1'b0;
        hold_dec     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new load wipes the previous image and status up front so
                // a shorter program never leaves stale words behind.
                if (bus._start) begin
                    state_d      = ST_HDR_PC;
                    error_d      = 1'b0;
                    run_cycles_d = '0;
                    buf_d        = '0;
                end
            end

            ST_HDR_PC: begin
                if (accept) begin
                    pc_d    = bus._in_data;
                    state_d = ST_HDR_CNT;
                end
            end

            ST_HDR_CNT: begin
                // The full 32-bit count is range-checked before truncation
                if (accept) begin
                    if (count_is_bad(bus._in_data, 32'(MAX_INSTS))) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        n_d     = bus._in_data[IDX_W-1:0];
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                // The index stops at N-1: the last word moves straight to HOLD
                if (accept) begin
                    for (int i = 0; i < MAX_INSTS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            buf_d[i] = bus._in_data;
                        end
                    end
                    if (idx_q == (n_q - IDX_W'(1))) begin
                        state_d   = ST_HOLD;
                        hold_load = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (hold_zero) begin
                    state_d = ST_RUN;
                end else begin
                    hold_dec = 1'b1;
                end
            end

            ST_RUN: begin
                // The finishing cycle is still counted as a run cycle
                run_cycles_d = sat_inc32(run_cycles_q);
                if (bus._core_finished) begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge _clk) begin
        if (_reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            buf_q        <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            error_q      <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            error_q      <= error_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    // The core runs only in RUN; every other state keeps it in reset
    assign bus.in_ready_      = in_ready;
    assign bus.core_reset_    = (state_q != ST_RUN);
    assign bus.init_pc_       = pc_q;
    assign bus.init_inst_buf_ = buf_q;
    assign bus.busy_          = (state_q == ST_HDR_PC) || (state_q == ST_HDR_CNT) ||
                                (state_q == ST_LOAD)   || (state_q == ST_HOLD)    ||
                                (state_q == ST_RUN);
    assign bus.done_          = (state_q == ST_DONE);
    assign bus.error_         = error_q;
    assign bus.run_cycles_    = run_cycles_q;

endmodule

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
// Purpose : Directed self-checking bench for program_loader with an 8-word
//           buffer and a reset hold of 4 cycles.
// ----------------------------------------------------------------------------
module tb_program_loader;

    localparam int MAX  = 8;
    localparam int HOLD = 4;

    localparam logic [31:0] WORD_A = 32'hA0A0_0001;
    localparam logic [31:0] WORD_B = 32'hB0B0_0002;
    localparam logic [31:0] WORD_C = 32'hC0C0_0003;
    localparam logic [31:0] WORD_D = 32'hD0D0_0004;
    localparam logic [31:0] WORD_X = 32'h1111_0005;
    localparam logic [31:0] WORD_Y = 32'h2222_0006;
    localparam logic [31:0] WORD_Z = 32'h3333_0007;
    localparam logic [31:0] WORD_P = 32'h4444_0008;
    localparam logic [31:0] WORD_Q = 32'h5555_0009;

    logic clk = 1'b0;
    logic rst;
    int   cyc     = 0;
    int   checks  = 0;
    int   passed  = 0;
    int   failed  = 0;
    int   tAcc;
    logic sawLow;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    program_loader_if #(.MAX_INSTS(MAX)) bus ();

    program_loader #(
        .MAX_INSTS  (MAX),
        .RESET_HOLD (HOLD)
    ) dut (
        ._clk   (clk),
        ._reset (rst),
        .bus    (bus)
    );

    // Advance one cycle; everything is sampled and driven 1 unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One comparison: counts it, and reports it when it does not hold
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
            $error("[TB] check %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Offer one stream word after an idle gap, wait (bounded) until it is
    // accepted; accCycle is the cycle in which valid & ready were both high
    task automatic applyStimulus(input logic [31:0] word, input int gap,
                                 output int accCycle);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        accCycle = cyc;
        bus._in_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
        bus._in_valid = 1'b1;
        bus._in_data  = word;
        for (int i = 0; i < 40; i++) begin
            rdy      = bus.in_ready_;
            accCycle = cyc;
            step();
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        bus._in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic pulseStart();
        bus._start = 1'b1;
        step();
        bus._start = 1'b0;
    endtask

    // Wait (bounded) for the core reset to fall and check its latency
    task automatic waitCoreRun(input int accCycle, input string tag);
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.core_reset_ == 1'b0) break;
        end
        checkOutput({tag, "_release_latency"}, 32'(cyc - accCycle), 32'd5);
    endtask

    // Watch that the core is never released for a number of cycles
    task automatic watchNoRelease(input int n, output logic low);
        low = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.core_reset_ == 1'b0) low = 1'b1;
        end
    endtask

    // Hard stop in case something wedges the sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence: reset, nominal load/run/finish, reload, bad counts,
    // gapped stream, resets mid-load and mid-run, final reload
    initial begin
        rst                = 1'b1;
        bus._start         = 1'b0;
        bus._in_valid      = 1'b0;
        bus._in_data       = '0;
        bus._core_finished = 1'b0;
        step(); step(); step();

        checkOutput("rst_in_ready",   32'(bus.in_ready_),   32'd0);
        checkOutput("rst_core_reset", 32'(bus.core_reset_), 32'd1);
        checkOutput("rst_init_pc",    bus.init_pc_,         32'd0);
        checkOutput("rst_busy",       32'(bus.busy_),       32'd0);
        checkOutput("rst_done",       32'(bus.done_),       32'd0);
        checkOutput("rst_error",      32'(bus.error_),      32'd0);
        checkOutput("rst_run_cycles", bus.run_cycles_,      32'd0);
        checkOutput("rst_buf0",       bus.init_inst_buf_[0], 32'd0);
        rst = 1'b0;
        step();

        // Nominal frame {0x100, 3, A, B, C}
        pulseStart();
        checkOutput("t1_busy",     32'(bus.busy_),     32'd1);
        checkOutput("t1_in_ready", 32'(bus.in_ready_), 32'd1);
        applyStimulus(32'h100, 0, tAcc);
        applyStimulus(32'd3,   0, tAcc);
        applyStimulus(WORD_A,  0, tAcc);
        applyStimulus(WORD_B,  0, tAcc);
        applyStimulus(WORD_C,  0, tAcc);
        checkOutput("t1_ready_drop", 32'(bus.in_ready_),   32'd0);
        checkOutput("t1_hold_reset", 32'(bus.core_reset_), 32'd1);
        waitCoreRun(tAcc, "t1");
        checkOutput("t1_init_pc", bus.init_pc_,          32'h100);
        checkOutput("t1_buf0",    bus.init_inst_buf_[0], WORD_A);
        checkOutput("t1_buf1",    bus.init_inst_buf_[1], WORD_B);
        checkOutput("t1_buf2",    bus.init_inst_buf_[2], WORD_C);
        for (int i = 3; i < MAX; i++) begin
            checkOutput($sformatf("t1_buf%0d_zero", i), bus.init_inst_buf_[3'(i)], 32'd0);
        end
        checkOutput("t1_run_start", bus.run_cycles_, 32'd0);

        // Finished pulses on the 11th RUN cycle
        for (int i = 0; i < 10; i++) step();
        bus._core_finished = 1'b1;
        step();
        bus._core_finished = 1'b0;
        checkOutput("t2_done",       32'(bus.done_),       32'd1);
        checkOutput("t2_run_cycles", bus.run_cycles_,      32'd11);
        checkOutput("t2_core_reset", 32'(bus.core_reset_), 32'd1);
        checkOutput("t2_busy",       32'(bus.busy_),       32'd0);
        bus._core_finished = 1'b1;
        step(); step();
        bus._core_finished = 1'b0;
        checkOutput("t2_run_frozen", bus.run_cycles_, 32'd11);
        checkOutput("t2_done_held",  32'(bus.done_),  32'd1);
        checkOutput("t2_buf_held",   bus.init_inst_buf_[2], WORD_C);

        // Reload from DONE with a single instruction
        pulseStart();
        checkOutput("t6_done_clr",  32'(bus.done_),  32'd0);
        checkOutput("t6_run_clr",   bus.run_cycles_, 32'd0);
        checkOutput("t6_buf1_clr",  bus.init_inst_buf_[1], 32'd0);
        applyStimulus(32'h80, 0, tAcc);
        applyStimulus(32'd1,  0, tAcc);
        applyStimulus(WORD_Z, 0, tAcc);
        waitCoreRun(tAcc, "t6");
        checkOutput("t6_init_pc", bus.init_pc_,          32'h80);
        checkOutput("t6_buf0",    bus.init_inst_buf_[0], WORD_Z);
        checkOutput("t6_buf1",    bus.init_inst_buf_[1], 32'd0);
        checkOutput("t6_buf2",    bus.init_inst_buf_[2], 32'd0);
        bus._core_finished = 1'b1;
        step();
        bus._core_finished = 1'b0;
        checkOutput("t6_done",       32'(bus.done_),  32'd1);
        checkOutput("t6_run_cycles", bus.run_cycles_, 32'd1);

        // Bad count N=0
        pulseStart();
        applyStimulus(32'h0, 0, tAcc);
        applyStimulus(32'd0, 0, tAcc);
        checkOutput("t3_n0_error",      32'(bus.error_),      32'd1);
        checkOutput("t3_n0_busy",       32'(bus.busy_),       32'd0);
        checkOutput("t3_n0_in_ready",   32'(bus.in_ready_),   32'd0);
        checkOutput("t3_n0_core_reset", 32'(bus.core_reset_), 32'd1);
        watchNoRelease(10, sawLow);
        checkOutput("t3_n0_no_release", 32'(sawLow),          32'd0);

        // Bad count N=MAX+1
        pulseStart();
        checkOutput("t3_error_clr", 32'(bus.error_), 32'd0);
        applyStimulus(32'h0, 0, tAcc);
        applyStimulus(32'(MAX + 1), 0, tAcc);
        checkOutput("t3_big_error", 32'(bus.error_), 32'd1);
        checkOutput("t3_big_busy",  32'(bus.busy_),  32'd0);
        watchNoRelease(10, sawLow);
        checkOutput("t3_big_no_release", 32'(sawLow),     32'd0);
        checkOutput("t3_error_sticky",   32'(bus.error_), 32'd1);

        // Gapped stream, then an extra word that must not be taken
        pulseStart();
        checkOutput("t4_error_clr", 32'(bus.error_), 32'd0);
        applyStimulus(32'h100, 2, tAcc);
        applyStimulus(32'd3,   1, tAcc);
        applyStimulus(WORD_A,  $urandom_range(1, 3), tAcc);
        applyStimulus(WORD_B,  $urandom_range(1, 3), tAcc);
        applyStimulus(WORD_C,  $urandom_range(1, 3), tAcc);
        bus._in_valid = 1'b1;
        bus._in_data  = WORD_D;
        checkOutput("t4_extra_not_ready", 32'(bus.in_ready_), 32'd0);
        waitCoreRun(tAcc, "t4");
        checkOutput("t4_init_pc", bus.init_pc_,          32'h100);
        checkOutput("t4_buf0",    bus.init_inst_buf_[0], WORD_A);
        checkOutput("t4_buf1",    bus.init_inst_buf_[1], WORD_B);
        checkOutput("t4_buf2",    bus.init_inst_buf_[2], WORD_C);
        checkOutput("t4_buf3",    bus.init_inst_buf_[3], 32'd0);
        bus._in_valid = 1'b0;

        // Reset while running
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("t5r_run_cycles", bus.run_cycles_,      32'd0);
        checkOutput("t5r_core_reset", 32'(bus.core_reset_), 32'd1);
        checkOutput("t5r_busy",       32'(bus.busy_),       32'd0);
        checkOutput("t5r_in_ready",   32'(bus.in_ready_),   32'd0);
        checkOutput("t5r_init_pc",    bus.init_pc_,         32'd0);
        checkOutput("t5r_buf0",       bus.init_inst_buf_[0], 32'd0);

        // Reset while loading
        pulseStart();
        applyStimulus(32'h200, 0, tAcc);
        applyStimulus(32'd4,   0, tAcc);
        applyStimulus(WORD_X,  0, tAcc);
        rst           = 1'b1;
        bus._in_valid = 1'b1;
        bus._in_data  = WORD_Y;
        step();
        rst           = 1'b0;
        bus._in_valid = 1'b0;
        checkOutput("t5l_init_pc",    bus.init_pc_,         32'd0);
        checkOutput("t5l_buf0",       bus.init_inst_buf_[0], 32'd0);
        checkOutput("t5l_busy",       32'(bus.busy_),       32'd0);
        checkOutput("t5l_in_ready",   32'(bus.in_ready_),   32'd0);
        checkOutput("t5l_core_reset", 32'(bus.core_reset_), 32'd1);

        // Fresh load after the resets
        pulseStart();
        applyStimulus(32'h40, 0, tAcc);
        applyStimulus(32'd2,  0, tAcc);
        applyStimulus(WORD_P, 0, tAcc);
        applyStimulus(WORD_Q, 0, tAcc);
        waitCoreRun(tAcc, "t5n");
        checkOutput("t5n_init_pc", bus.init_pc_,          32'h40);
        checkOutput("t5n_buf0",    bus.init_inst_buf_[0], WORD_P);
        checkOutput("t5n_buf1",    bus.init_inst_buf_[1], WORD_Q);
        checkOutput("t5n_buf2",    bus.init_inst_buf_[2], 32'd0);
        step(); step();
        bus._core_finished = 1'b1;
        step();
        bus._core_finished = 1'b0;
        checkOutput("t5n_done",       32'(bus.done_),  32'd1);
        checkOutput("t5n_run_cycles", bus.run_cycles_, 32'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
